sio_host: RTL

Host-side master for the remote-IO serial link. It runs the fixed 128-clock frame toward one remote receiver target over the single shared DDR data line. Each frame it sends one 20-bit command (4-bit address, 16-bit data), then deserializes the target's 24 ADC bytes and 16-bit readback. It sits between the host's command and ADC-capture logic and the pad-level DDR I/O cell; the I/O primitive lives outside this block.

---
 rtl/sio_pkg.sv | 28 ++
 rtl/sio_host_rx.sv | 39 +++
 rtl/sio_host.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sio_pkg.sv
// Shared constants and types for the remote-IO serial link host.
package sio_pkg;

    localparam int FRAME_LEN   = 128;
    localparam int CMD_PAIRS   = 10;
    localparam int N_ADC_BYTES = 24;
    localparam int N_RX_BYTES  = 26;
    localparam int RX_PAIRS    = N_RX_BYTES * 4;

    localparam logic [3:0] NOP_ADDR_DEFAULT = 4'hF;
    localparam logic [3:0] ADDR_SYNC        = 4'd1;
    localparam logic [3:0] ADDR_SPI0        = 4'd2;
    localparam logic [3:0] ADDR_SPI1        = 4'd3;
    localparam logic [3:0] ADDR_CHERR       = 4'd6;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_ARM,
        ST_RUN,
        ST_IDLE
    } host_state_e;

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } cmd_word_t;

endpackage

// File: rtl/sio_host_rx.sv
// Deserializes DDR bit pairs into bytes over the receive window of a frame.
module sio_host_rx
    import sio_pkg::*;
#(
    parameter int RX_OFFSET = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       active_i,
    input  logic [6:0] fc_i,
    input  logic [1:0] sdio_di_i,
    output logic       byte_vld_o,
    output logic [4:0] byte_idx_o,
    output logic [7:0] byte_data_o
);

    localparam logic [7:0] OFFSET = 8'(RX_OFFSET);
    localparam logic [7:0] WINDOW = 8'(RX_PAIRS);

    logic [7:0] rel;
    logic       in_win;
    logic [5:0] sh_q;

    // Before the window the subtraction wraps high, so one compare bounds both ends.
    assign rel         = {1'b0, fc_i} - OFFSET;
    assign in_win      = active_i && (rel < WINDOW);
    assign byte_vld_o  = in_win && (rel[1:0] == 2'd3);
    assign byte_idx_o  = rel[6:2];
    assign byte_data_o = {sh_q, sdio_di_i};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sh_q <= '0;
        end else if (in_win && (rel[1:0] != 2'd3)) begin
            sh_q <= {sh_q[3:0], sdio_di_i};
        end
    end

endmodule

// File: rtl/sio_host.sv
// Host master for the remote-IO link: sends one command per 128-cycle frame and
// collects the target's ADC bytes and register readback.
module sio_host
    import sio_pkg::*;
#(
    parameter int         RX_OFFSET = 16,
    parameter logic [3:0] NOP_ADDR  = NOP_ADDR_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    output logic        sdio_oe,
    output logic [1:0]  sdio_do,
    input  logic [1:0]  sdio_di,
    output logic        adc_valid,
    output logic [4:0]  adc_index,
    output logic [7:0]  adc_data,
    output logic        rsp_valid,
    output logic [3:0]  rsp_addr,
    output logic [15:0] rsp_data,
    output logic        link_error,
    output logic        frame_start
);

    localparam logic [6:0] FC_LAST = 7'(FRAME_LEN - 1);
    localparam logic [4:0] IDX_HI  = 5'(N_RX_BYTES - 2);
    localparam logic [4:0] IDX_LO  = 5'(N_RX_BYTES - 1);

    host_state_e state_q;
    logic [6:0]  fc_q;
    logic        cmd_ready_q, sdio_oe_q, frame_start_q;
    logic [1:0]  sdio_do_q;
    logic        tx_nop_q, pend_vld_q;
    logic [15:0] nop_q;
    logic [19:0] tx_sh_q;
    cmd_word_t   tx_word_q, pend_q;
    logic [7:0]  rb_hi_q;
    logic        adc_valid_q, rsp_valid_q, link_error_q;
    logic [4:0]  adc_index_q;
    logic [7:0]  adc_data_q;
    logic [3:0]  rsp_addr_q;
    logic [15:0] rsp_data_q;

    logic        accept, wrap, start, shift_en;
    logic [6:0]  fc_inc;
    cmd_word_t   frame_word_d;
    logic        frame_nop_d;
    logic        rx_vld;
    logic [4:0]  rx_idx;
    logic [7:0]  rx_data;
    logic [15:0] rb_word;

    assign accept   = cmd_ready_q && cmd_valid;
    assign fc_inc   = fc_q + 7'd1;
    assign wrap     = (state_q == ST_RUN) && (fc_q == FC_LAST);
    assign start    = (state_q == ST_ARM) || ((state_q == ST_IDLE) && enable) || (wrap && enable);
    assign shift_en = (state_q == ST_RUN) && !wrap && (fc_inc <= 7'(CMD_PAIRS));
    assign rb_word  = {rb_hi_q, rx_data};

    // A command accepted just before an idle period waits in pend_q for the next frame.
    always_comb begin
        frame_nop_d = 1'b0;
        if (accept) begin
            frame_word_d = '{addr: cmd_addr, data: cmd_data};
        end else if (pend_vld_q) begin
            frame_word_d = pend_q;
        end else begin
            frame_word_d = '{addr: NOP_ADDR, data: nop_q};
            frame_nop_d  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_BOOT;
            fc_q          <= '0;
            cmd_ready_q   <= 1'b0;
            sdio_oe_q     <= 1'b0;
            sdio_do_q     <= 2'b11;
            frame_start_q <= 1'b0;
            tx_nop_q      <= 1'b0;
            pend_vld_q    <= 1'b0;
            nop_q         <= '0;
        end else begin
            frame_start_q <= 1'b0;
            cmd_ready_q   <= 1'b0;
            if (accept && !start) begin
                pend_vld_q <= 1'b1;
            end
            if (start) begin
                state_q       <= ST_RUN;
                fc_q          <= '0;
                frame_start_q <= 1'b1;
                sdio_oe_q     <= 1'b1;
                sdio_do_q     <= 2'b00;
                tx_nop_q      <= frame_nop_d;
                pend_vld_q    <= 1'b0;
                if (frame_nop_d) begin
                    nop_q <= nop_q + 16'd1;
                end
            end else begin
                case (state_q)
                    ST_BOOT: begin
                        state_q     <= ST_ARM;
                        cmd_ready_q <= 1'b1;
                    end
                    ST_RUN: begin
                        if (wrap) begin
                            state_q   <= ST_IDLE;
                            fc_q      <= '0;
                            sdio_oe_q <= 1'b0;
                            sdio_do_q <= 2'b11;
                        end else begin
                            fc_q        <= fc_inc;
                            cmd_ready_q <= (fc_inc == FC_LAST);
                            if (shift_en) begin
                                sdio_do_q <= tx_sh_q[19:18];
                            end else begin
                                sdio_oe_q <= 1'b0;
                                sdio_do_q <= 2'b11;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (start) begin
            tx_word_q <= frame_word_d;
            tx_sh_q   <= frame_word_d;
        end else if (shift_en) begin
            tx_sh_q <= {tx_sh_q[17:0], 2'b00};
        end
        if (accept && !start) begin
            pend_q <= '{addr: cmd_addr, data: cmd_data};
        end
        if (rx_vld && (rx_idx == IDX_HI)) begin
            rb_hi_q <= rx_data;
        end
    end

    sio_host_rx #(
        .RX_OFFSET(RX_OFFSET)
    ) u_rx (
        .clk_i      (clock),
        .rst_ni     (reset_n),
        .active_i   (state_q == ST_RUN),
        .fc_i       (fc_q),
        .sdio_di_i  (sdio_di),
        .byte_vld_o (rx_vld),
        .byte_idx_o (rx_idx),
        .byte_data_o(rx_data)
    );

    // tx_word_q/tx_nop_q still describe this frame even when rsp lands on the wrap edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            adc_valid_q  <= 1'b0;
            adc_index_q  <= '0;
            adc_data_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_addr_q   <= '0;
            rsp_data_q   <= '0;
            link_error_q <= 1'b0;
        end else begin
            adc_valid_q <= rx_vld && (rx_idx < 5'(N_ADC_BYTES));
            rsp_valid_q <= rx_vld && (rx_idx == IDX_LO);
            if (rx_vld && (rx_idx < 5'(N_ADC_BYTES))) begin
                adc_index_q <= rx_idx;
                adc_data_q  <= rx_data;
            end
            if (rx_vld && (rx_idx == IDX_LO)) begin
                rsp_addr_q <= tx_word_q.addr;
                rsp_data_q <= rb_word;
                if (tx_nop_q && (rb_word != tx_word_q.data)) begin
                    link_error_q <= 1'b1;
                end
            end
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign sdio_oe     = sdio_oe_q;
    assign sdio_do     = sdio_do_q;
    assign frame_start = frame_start_q;
    assign adc_valid   = adc_valid_q;
    assign adc_index   = adc_index_q;
    assign adc_data    = adc_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_addr    = rsp_addr_q;
    assign rsp_data    = rsp_data_q;
    assign link_error  = link_error_q;

endmodule
